// File: rtl/apb_i2c_cmd_sequencer.sv
// Purpose: APB master that turns one host command into one APB transfer against the I2C bridge slave.
// Latency: with a zero-wait slave, a command accepted at edge N gives SETUP at N+1, ACCESS at N+2 and rsp_valid from N+3.
// Backpressure: cmd_ready is high only in IDLE; the response is held until rsp_ready; PREADY and RX-empty waits are bounded by a watchdog.
module apb_i2c_cmd_sequencer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int DATA_W         = 32
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [31:0]       PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    input  logic              INT_RX
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RX,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    // Next-state, watchdog counter, command latch and response capture.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (cmd_valid) begin
                    // Register map is word-spaced: op selects offset op*4.
                    paddr_d  = {28'd0, cmd_op, 2'b00};
                    pwrite_d = (cmd_op != 2'd1);
                    pwdata_d = (cmd_op == 2'd1) ? '0 : cmd_data;
                    // A pop while the RX FIFO is empty must wait for data first.
                    if (cmd_op == 2'd1 && INT_RX) begin
                        state_d = S_WAIT_RX;
                    end else begin
                        state_d = S_SETUP;
                    end
                end
            end
            S_WAIT_RX: begin
                if (!INT_RX) begin
                    state_d = S_SETUP;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = S_RESP;
                    rsp_timeout_d = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_data_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SETUP: begin
                cnt_d   = '0;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                // PREADY is checked first so a late ready on the last cycle still completes.
                if (PREADY) begin
                    state_d       = S_RESP;
                    rsp_data_d    = pwrite_q ? '0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = S_RESP;
                    rsp_timeout_d = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_data_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign rsp_valid   = (state_q == S_RESP);
    assign PSELx       = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign PENABLE     = (state_q == S_ACCESS);
    assign PADDR       = paddr_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule
